// File: rtl/po2_mac.sv
// po2_mac: power-of-two weighted dot product, one lane per cycle.
// Each lane input (Q(I).(W-I)) is widened to Q(2I).(2W-2I), optionally
// negated, arithmetically shifted right by its log2 weight, and summed
// into a non-wrapping accumulator. The sum is clamped to 2W bits.
module po2_mac #(
    parameter int W  = 16,
    parameter int I  = 4,
    parameter int N  = 4,
    parameter int SW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_v,
    output logic              in_ready,
    input  logic [N*W-1:0]    inp,
    input  logic [N-1:0]      negative_weight,
    input  logic [N-1:0]      zero_weight,
    input  logic [N*SW-1:0]   log_2_weight,
    input  logic              out_ready,
    output logic [2*W-1:0]    result,
    output logic              result_v,
    output logic              result_sat
);

    localparam int TW  = 2 * W;
    localparam int AW  = TW + $clog2(N) + 1;
    localparam int LIW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT, DONE} state_t;

    state_t                 state_q, state_d;

    logic [N*W-1:0]         inp_q;
    logic [N-1:0]           neg_q;
    logic [N-1:0]           zero_q;
    logic [N*SW-1:0]        sh_q;

    logic [LIW-1:0]         idx_q;
    logic signed [TW-1:0]   term_q;
    logic signed [TW-1:0]   term_d;
    logic signed [AW-1:0]   acc_q;
    logic [TW-1:0]          result_q;
    logic                   result_v_q;
    logic                   sat_q;
    logic [TW:0]            sat_res;

    // Widen, optionally negate at full 2W width (so -2^(I-1) negates
    // exactly), shift with sign fill, then force to zero if flagged.
    function automatic logic signed [TW-1:0] lane_term(
        input logic [W-1:0]  x,
        input logic          neg,
        input logic          zero,
        input logic [SW-1:0] sh
    );
        logic signed [TW-1:0] wide;
        logic signed [TW-1:0] t;
        wide = {{I{x[W-1]}}, x, {(W-I){1'b0}}};
        if (neg) begin
            wide = -wide;
        end
        if (int'(sh) >= TW) begin
            t = {TW{wide[TW-1]}};
        end else begin
            t = wide >>> sh;
        end
        if (zero) begin
            t = '0;
        end
        return t;
    endfunction

    // Clamp the wide accumulator to the 2W result range; returns {clipped, value}.
    function automatic logic [TW:0] saturate(input logic signed [AW-1:0] a);
        logic [TW:0] r;
        if (a[AW-1:TW-1] == {(AW-TW+1){a[AW-1]}}) begin
            r = {1'b0, a[TW-1:0]};
        end else if (a[AW-1]) begin
            r = {1'b1, 1'b1, {(TW-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(TW-1){1'b1}}};
        end
        return r;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ACCUM keeps one extra cycle to fold in the
    // term of the last lane, which sits in the term pipeline register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_v) state_d = ACCUM;
            ACCUM:   if (idx_q == LIW'(N)) state_d = SAT;
            SAT:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Select the current lane and form its term.
    always_comb begin
        term_d = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx_q) == k) begin
                term_d = lane_term(inp_q[k*W +: W], neg_q[k], zero_q[k], sh_q[k*SW +: SW]);
            end
        end
    end

    always_comb begin
        sat_res = saturate(acc_q);
    end

    // Capture the operand bundle on accept; held untouched until the next accept.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && in_v) begin
            inp_q  <= inp;
            neg_q  <= negative_weight;
            zero_q <= zero_weight;
            sh_q   <= log_2_weight;
        end
    end

    // Accumulation, saturation and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            term_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            result_v_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_v) begin
                        idx_q  <= '0;
                        term_q <= '0;
                        acc_q  <= '0;
                    end
                end
                ACCUM: begin
                    acc_q  <= acc_q + {{(AW-TW){term_q[TW-1]}}, term_q};
                    term_q <= term_d;
                    if (idx_q != LIW'(N)) begin
                        idx_q <= idx_q + LIW'(1);
                    end
                end
                SAT: begin
                    result_q   <= sat_res[TW-1:0];
                    sat_q      <= sat_res[TW];
                    result_v_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        result_v_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result     = result_q;
    assign result_v   = result_v_q;
    assign result_sat = sat_q;

endmodule
